// File: rtl/deser_align_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_align_ctrl_pkg
// Description : Lane state encodings and a constant clog2 helper shared by the
//               deserializer word-alignment controller.
// Revision    : 1.0 - initial release
// ============================================================================
package deser_align_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } lane_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_align_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : deser_align_ctrl_if
// Description : Data, status and bitslip bundle between deserializer-side
//               logic and the word-alignment controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface deser_align_ctrl_if #(
    parameter int CHANNEL_NUM = 4,
    parameter int DESER_WIDTH = 6
);
    logic [CHANNEL_NUM*DESER_WIDTH-1:0] iv_data;
    logic                               i_bufpll_lock;
    logic                               i_train_en;
    logic [CHANNEL_NUM-1:0]             ov_bitslip;
    logic [CHANNEL_NUM-1:0]             ov_lane_ok;
    logic                               o_align_done;
    logic                               o_align_err;
    logic [CHANNEL_NUM*DESER_WIDTH-1:0] ov_data;

    modport master (
        output iv_data, i_bufpll_lock, i_train_en,
        input  ov_bitslip, ov_lane_ok, o_align_done, o_align_err, ov_data
    );

    modport slave (
        input  iv_data, i_bufpll_lock, i_train_en,
        output ov_bitslip, ov_lane_ok, o_align_done, o_align_err, ov_data
    );
endinterface
`default_nettype wire

// File: rtl/deser_align_ctrl_lane.sv
`default_nettype none
// ============================================================================
// Module      : deser_align_lane
// Description : Per-lane training FSM: compares the registered word against the
//               training pattern and issues spaced bitslip pulses until lock/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_align_lane
    import deser_align_ctrl_pkg::*;
#(
    parameter int                     DESER_WIDTH   = 6,
    parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 6'b111000,
    parameter int                     SLIP_WAIT     = 3,
    parameter int                     MATCH_CNT     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DESER_WIDTH-1:0] i_word,
    input  logic                   i_bufpll_lock,
    input  logic                   i_train_en,
    output logic                   o_bitslip,
    output logic                   o_lane_ok,
    output logic                   o_fail
);
    localparam int c_SLIP_W  = (clog2(DESER_WIDTH) > 0) ? clog2(DESER_WIDTH) : 1;
    localparam int c_MATCH_W = (clog2(MATCH_CNT + 1) > 0) ? clog2(MATCH_CNT + 1) : 1;
    localparam int c_WAIT_W  = (clog2(SLIP_WAIT + 1) > 0) ? clog2(SLIP_WAIT + 1) : 1;

    localparam logic [c_SLIP_W-1:0]  c_SLIP_MAX  = c_SLIP_W'(DESER_WIDTH - 1);
    localparam logic [c_SLIP_W-1:0]  c_SLIP_ONE  = c_SLIP_W'(1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_MAX = c_MATCH_W'(MATCH_CNT);
    localparam logic [c_MATCH_W-1:0] c_MATCH_ONE = c_MATCH_W'(1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(SLIP_WAIT - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE  = c_WAIT_W'(1);

    lane_state_e            r_state;
    lane_state_e            w_state_nx;
    logic [c_SLIP_W-1:0]    r_slip_cnt;
    logic [c_SLIP_W-1:0]    w_slip_nx;
    logic [c_MATCH_W-1:0]   r_match_cnt;
    logic [c_MATCH_W-1:0]   w_match_nx;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic [c_WAIT_W-1:0]    w_wait_nx;
    logic                   w_match;

    assign w_match = (i_word == TRAIN_PATTERN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_slip_cnt  <= '0;
            r_match_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_slip_cnt  <= w_slip_nx;
            r_match_cnt <= w_match_nx;
            r_wait_cnt  <= w_wait_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_slip_nx  = r_slip_cnt;
        w_match_nx = r_match_cnt;
        w_wait_nx  = r_wait_cnt;

        // Losing PLL lock or the training request aborts from any state,
        // so a slip decided in this cycle never reaches the SLIP state.
        if (!i_bufpll_lock || !i_train_en) begin
            w_state_nx = ST_IDLE;
            w_slip_nx  = '0;
            w_match_nx = '0;
            w_wait_nx  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_CHECK;
                    w_slip_nx  = '0;
                    w_match_nx = '0;
                    w_wait_nx  = '0;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt < c_MATCH_MAX) begin
                            w_match_nx = r_match_cnt + c_MATCH_ONE;
                        end
                        if (r_match_cnt + c_MATCH_ONE >= c_MATCH_MAX) begin
                            w_state_nx = ST_LOCKED;
                        end
                    end else begin
                        w_match_nx = '0;
                        w_state_nx = (r_slip_cnt < c_SLIP_MAX) ? ST_SLIP : ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    if (r_slip_cnt < c_SLIP_MAX) begin
                        w_slip_nx = r_slip_cnt + c_SLIP_ONE;
                    end
                    w_wait_nx  = '0;
                    w_state_nx = (SLIP_WAIT == 0) ? ST_CHECK : ST_WAIT;
                end
                ST_WAIT: begin
                    // Give the deserializer time to apply the slip and the
                    // input register time to show the shifted word.
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state_nx = ST_CHECK;
                    end else begin
                        w_wait_nx = r_wait_cnt + c_WAIT_ONE;
                    end
                end
                ST_LOCKED: w_state_nx = ST_LOCKED;
                ST_FAIL:   w_state_nx = ST_FAIL;
                default:   w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign o_bitslip = (r_state == ST_SLIP);
    assign o_lane_ok = (r_state == ST_LOCKED);
    assign o_fail    = (r_state == ST_FAIL);

endmodule
`default_nettype wire

// File: rtl/deser_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : deser_align_ctrl
// Description : Multi-lane deserializer word alignment: input register, one
//               training FSM per lane, and registered done/error reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_align_ctrl
    import deser_align_ctrl_pkg::*;
#(
    parameter int                     CHANNEL_NUM   = 4,
    parameter int                     DESER_WIDTH   = 6,
    parameter logic [DESER_WIDTH-1:0] TRAIN_PATTERN = 6'b111000,
    parameter int                     SLIP_WAIT     = 3,
    parameter int                     MATCH_CNT     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    deser_align_ctrl_if.slave  bus
);
    localparam int c_BUS_W = CHANNEL_NUM * DESER_WIDTH;

    logic [c_BUS_W-1:0]     r_data;
    logic                   r_done;
    logic                   r_err;
    logic                   w_run;
    logic [CHANNEL_NUM-1:0] w_bitslip;
    logic [CHANNEL_NUM-1:0] w_lane_ok;
    logic [CHANNEL_NUM-1:0] w_lane_fail;

    // Gating with the run condition lets done/err drop on the same edge
    // that sends the lanes back to IDLE.
    assign w_run = bus.i_train_en & bus.i_bufpll_lock;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_data <= bus.iv_data;
            r_done <= w_run & (&(w_lane_ok | w_lane_fail));
            r_err  <= w_run & (|w_lane_fail);
        end
    end

    generate
        for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_lane
            deser_align_lane #(
                .DESER_WIDTH   (DESER_WIDTH),
                .TRAIN_PATTERN (TRAIN_PATTERN),
                .SLIP_WAIT     (SLIP_WAIT),
                .MATCH_CNT     (MATCH_CNT)
            ) u_lane (
                .clk           (clk),
                .reset_n       (reset_n),
                .i_word        (r_data[k*DESER_WIDTH +: DESER_WIDTH]),
                .i_bufpll_lock (bus.i_bufpll_lock),
                .i_train_en    (bus.i_train_en),
                .o_bitslip     (w_bitslip[k]),
                .o_lane_ok     (w_lane_ok[k]),
                .o_fail        (w_lane_fail[k])
            );
        end
    endgenerate

    assign bus.ov_data      = r_data;
    assign bus.ov_bitslip   = w_bitslip;
    assign bus.ov_lane_ok   = w_lane_ok;
    assign bus.o_align_done = r_done;
    assign bus.o_align_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_deser_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_deser_align_ctrl
// Description : Scoreboard bench: a rotating-word deserializer model feeds the
//               controller; expected event cycles come from timing arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deser_align_ctrl;
    localparam int          c_N     = 4;
    localparam int          c_W     = 6;
    localparam int          c_SW    = 3;
    localparam int          c_MC    = 4;
    localparam logic [5:0]  c_PAT   = 6'b111000;
    localparam int          c_P     = c_SW + 2;
    localparam int          c_NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    deser_align_ctrl_if #(.CHANNEL_NUM(c_N), .DESER_WIDTH(c_W)) bus ();

    deser_align_ctrl #(
        .CHANNEL_NUM(c_N), .DESER_WIDTH(c_W), .TRAIN_PATTERN(c_PAT),
        .SLIP_WAIT(c_SW), .MATCH_CNT(c_MC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          horizon = 0;
    int          slips_seen [c_N] = '{default: 0};
    int          base       [c_N];
    logic [5:0]  seed       [c_N];
    int          q_slip [c_N][$];
    int          q_ok   [c_N][$];
    int          q_done [$];
    int          q_err  [$];
    logic [c_N*c_W-1:0] iv_bus;
    logic [c_N*c_W-1:0] last_iv;
    logic        last_rst;

    function automatic logic [5:0] rotl(input logic [5:0] w, input int n);
        logic [5:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    function automatic int slips_needed(input logic [5:0] w);
        for (int r = 0; r < c_W; r++) if (rotl(w, r) == c_PAT) return r;
        return -1;
    endfunction

    function automatic logic [5:0] fail_word();
        logic [5:0] w;
        for (int i = 0; i < 64; i++) begin
            w = 6'($urandom_range(0, 63));
            if (slips_needed(w) < 0) return w;
        end
        return 6'h00;
    endfunction

    // Deserializer model: each bitslip pulse seen rotates that lane by one bit.
    always_comb begin
        iv_bus = '0;
        for (int k = 0; k < c_N; k++)
            iv_bus[k*c_W +: c_W] = rotl(seed[k], (slips_seen[k] - base[k]) % c_W);
    end
    assign bus.iv_data = iv_bus;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_word(input int k, input logic [5:0] w);
        seed[k] = w;
        base[k] = slips_seen[k];
    endtask

    // Training starts at edge t0; events whose edge is at or after t_end are
    // cancelled by an abort sampled at t_end.
    task automatic plan(input int t0, input int t_end);
        int n, fin, done_c, err_c;
        logic [5:0] w;
        done_c = 0;
        err_c  = c_NEVER;
        for (int k = 0; k < c_N; k++) begin
            w = rotl(seed[k], (slips_seen[k] - base[k]) % c_W);
            n = slips_needed(w);
            if (n >= 0) begin
                for (int j = 0; j < n; j++)
                    if (t0 + 1 + c_P*j < t_end) q_slip[k].push_back(t0 + 1 + c_P*j);
                fin = t0 + c_P*n + c_MC;
                if (fin < t_end) q_ok[k].push_back(fin);
            end else begin
                for (int j = 0; j < c_W - 1; j++)
                    if (t0 + 1 + c_P*j < t_end) q_slip[k].push_back(t0 + 1 + c_P*j);
                fin = t0 + c_P*(c_W - 1) + 1;
                if (fin + 1 < err_c) err_c = fin + 1;
            end
            if (fin > done_c) done_c = fin;
        end
        done_c++;
        if (done_c < t_end) q_done.push_back(done_c);
        if (err_c < t_end) q_err.push_back(err_c);
        horizon = (t_end < c_NEVER) ? t_end + 2 : done_c + 3;
    endtask

    task automatic check_queues(input string tag);
        for (int k = 0; k < c_N; k++) begin
            chk($sformatf("%s_slip%0d_missing", tag, k), q_slip[k].size(), 0);
            chk($sformatf("%s_ok%0d_missing", tag, k), q_ok[k].size(), 0);
            q_slip[k].delete();
            q_ok[k].delete();
        end
        chk($sformatf("%s_done_missing", tag), q_done.size(), 0);
        chk($sformatf("%s_err_missing", tag), q_err.size(), 0);
        q_done.delete();
        q_err.delete();
    endtask

    task automatic start_train();
        @(negedge clk);
        plan(cyc + 1, c_NEVER);
        bus.i_train_en = 1'b1;
    endtask

    task automatic wait_horizon(input string tag);
        while (cyc < horizon) @(negedge clk);
        check_queues(tag);
    endtask

    task automatic stop_train(input string tag);
        @(negedge clk);
        bus.i_train_en = 1'b0;
        @(negedge clk);
        chk({tag, "_stop_lane_ok"}, bus.ov_lane_ok, 0);
        chk({tag, "_stop_done"}, bus.o_align_done, 0);
        chk({tag, "_stop_err"}, bus.o_align_err, 0);
        chk({tag, "_stop_bitslip"}, bus.ov_bitslip, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            last_iv  = bus.iv_data;
            last_rst = !reset_n;
        end
    end

    // Monitor: every output event pops the matching expectation.
    initial begin
        logic [c_N-1:0] prev_ok;
        logic prev_done, prev_err;
        int e;
        prev_ok = '0; prev_done = 1'b0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc > 0) chk("ov_data", bus.ov_data, last_rst ? '0 : last_iv);
            for (int k = 0; k < c_N; k++) begin
                if (bus.ov_bitslip[k] === 1'b1) begin
                    chk($sformatf("slip%0d_expected", k), q_slip[k].size() > 0, 1);
                    if (q_slip[k].size() > 0) begin
                        e = q_slip[k].pop_front();
                        chk($sformatf("slip%0d_cycle", k), cyc, e);
                    end
                    slips_seen[k]++;
                end
                if (bus.ov_lane_ok[k] === 1'b1 && !prev_ok[k]) begin
                    chk($sformatf("lock%0d_expected", k), q_ok[k].size() > 0, 1);
                    if (q_ok[k].size() > 0) begin
                        e = q_ok[k].pop_front();
                        chk($sformatf("lock%0d_cycle", k), cyc, e);
                    end
                end
            end
            if (bus.o_align_done === 1'b1 && !prev_done) begin
                chk("done_expected", q_done.size() > 0, 1);
                if (q_done.size() > 0) begin
                    e = q_done.pop_front();
                    chk("done_cycle", cyc, e);
                end
            end
            if (bus.o_align_err === 1'b1 && !prev_err) begin
                chk("err_expected", q_err.size() > 0, 1);
                if (q_err.size() > 0) begin
                    e = q_err.pop_front();
                    chk("err_cycle", cyc, e);
                end
            end
            prev_ok   = bus.ov_lane_ok;
            prev_done = bus.o_align_done;
            prev_err  = bus.o_align_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, r;
        reset_n = 1'b0;
        bus.i_train_en = 1'b0;
        bus.i_bufpll_lock = 1'b1;
        for (int k = 0; k < c_N; k++) set_word(k, c_PAT);
        repeat (3) @(negedge clk);
        chk("rst_lane_ok", bus.ov_lane_ok, 0);
        chk("rst_bitslip", bus.ov_bitslip, 0);
        chk("rst_done", bus.o_align_done, 0);
        chk("rst_err", bus.o_align_err, 0);
        chk("rst_data", bus.ov_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // All lanes already aligned.
        start_train();
        wait_horizon("aligned");
        chk("aligned_err", bus.o_align_err, 0);
        stop_train("aligned");

        // Lane 2 rotated by three bits.
        set_word(2, rotl(c_PAT, 3));
        start_train();
        wait_horizon("rot3");
        stop_train("rot3");

        // Lane 1 never matches.
        for (int k = 0; k < c_N; k++) set_word(k, c_PAT);
        set_word(1, 6'h00);
        start_train();
        wait_horizon("fail1");
        chk("fail1_err_level", bus.o_align_err, 1);
        stop_train("fail1");

        // PLL lock lost while lane 0 waits after its first slip.
        for (int k = 0; k < c_N; k++) set_word(k, c_PAT);
        set_word(0, rotl(c_PAT, 3));
        @(negedge clk);
        t0 = cyc + 1;
        plan(t0, t0 + 3);
        bus.i_train_en = 1'b1;
        while (cyc < t0 + 2) @(negedge clk);
        bus.i_bufpll_lock = 1'b0;
        @(negedge clk);
        chk("unlock_lane_ok", bus.ov_lane_ok, 0);
        chk("unlock_bitslip", bus.ov_bitslip, 0);
        repeat (4) @(negedge clk);
        chk("unlock_done", bus.o_align_done, 0);
        check_queues("unlock");
        plan(cyc + 1, c_NEVER);
        bus.i_bufpll_lock = 1'b1;
        wait_horizon("relock");
        stop_train("relock");

        // One-cycle reset after two slips on lane 3.
        for (int k = 0; k < c_N; k++) set_word(k, c_PAT);
        set_word(3, fail_word());
        @(negedge clk);
        t0 = cyc + 1;
        plan(t0, t0 + 8);
        bus.i_train_en = 1'b1;
        while (cyc < t0 + 7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_lane_ok", bus.ov_lane_ok, 0);
        chk("midrst_bitslip", bus.ov_bitslip, 0);
        chk("midrst_done", bus.o_align_done, 0);
        chk("midrst_err", bus.o_align_err, 0);
        check_queues("midrst");
        plan(cyc + 1, c_NEVER);
        reset_n = 1'b1;
        wait_horizon("postrst");
        stop_train("postrst");

        // Randomized lane offsets, including unalignable words.
        for (int round = 0; round < 6; round++) begin
            for (int k = 0; k < c_N; k++) begin
                r = $urandom_range(0, 6);
                if (r == 6) set_word(k, fail_word());
                else        set_word(k, rotl(c_PAT, (c_W - r) % c_W));
            end
            start_train();
            wait_horizon($sformatf("rand%0d", round));
            stop_train($sformatf("rand%0d", round));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
